// File: rtl/uart_tx_if.sv
// Byte-write and status bundle between the data-memory UART mapping and uart_tx.
interface uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_we;
  logic          overflow_clr;
  logic          tx;
  logic          busy;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output tx_data, tx_we, overflow_clr,
    input  tx, busy, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  tx_data, tx_we, overflow_clr,
    output tx, busy, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; status visible through bus.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          tx_q;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic fifo_empty;
  logic fifo_full_int;
  logic push;
  logic drop;
  logic pop;
  logic bit_tc;

  assign fifo_empty    = (count_q == '0);
  assign fifo_full_int = (count_q == CW'(FIFO_DEPTH));
  assign push          = bus.tx_we && !fifo_full_int;
  assign drop          = bus.tx_we && fifo_full_int;
  assign bit_tc        = (bit_cnt == BW'(CLKS_PER_BIT - 1));
  // The FSM takes the head byte when idle, or at the end of a stop bit for back-to-back frames.
  assign pop           = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_tc));

  // Byte storage; contents are don't-care while the matching slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.tx_data;
    end
  end

  // FIFO pointers and occupancy; a write seen while full is dropped even if a pop frees a slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit, with registered line output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift   <= mem[rptr];
            tx_q    <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_tc) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_tc) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_tc) begin
            bit_cnt <= '0;
            if (pop) begin
              shift <= mem[rptr];
              tx_q  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // Status is decoded straight from registered state.
  assign bus.tx         = tx_q;
  assign bus.busy       = (state != IDLE) || !fifo_empty;
  assign bus.fifo_full  = fifo_full_int;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of expected bytes checked by a line decoder.
module tb_uart_tx;
  logic clk;
  logic rst;

  int n_vec;
  int n_err;
  logic [7:0] exp_q[$];

  uart_tx_if #(.FIFO_DEPTH(4)) u_if ();

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_sent);
    u_if.tx_data = d;
    u_if.tx_we   = 1'b1;
    if (expect_sent) exp_q.push_back(d);
    tick();
    u_if.tx_we   = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n;
    n = 0;
    while (u_if.busy && n < lim) begin
      tick();
      n++;
    end
    chk({nm, "_drain"}, 32'(u_if.busy), 32'd0);
    tick_n(3);
  endtask

  // Line decoder: samples mid-bit at the falling clock edge and pops the scoreboard per frame.
  int         rx_ph;
  logic [7:0] rx_byte;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      rx_ph = -1;
    end else if (rx_ph < 0) begin
      if (u_if.tx === 1'b0) rx_ph = 0;
    end else begin
      rx_ph++;
      if (rx_ph == 2) chk("rx_start_bit", 32'(u_if.tx), 32'd0);
      if (rx_ph >= 6 && rx_ph <= 34 && ((rx_ph - 6) % 4) == 0)
        rx_byte[(rx_ph - 6) / 4] = u_if.tx;
      if (rx_ph == 38) begin
        chk("rx_stop_bit", 32'(u_if.tx), 32'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: got %02h, expected no frame", rx_byte);
        end else begin
          chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
      end
      if (rx_ph == 39) rx_ph = -1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0] STREAM [12] = '{8'hC3, 8'h3C, 8'h81, 8'h7E, 8'h00, 8'hFF,
                                         8'h5A, 8'hA5, 8'h12, 8'h34, 8'hE7, 8'h18};

  initial begin
    int exp_cnt [6];
    bit low_seen;
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    u_if.tx_data = '0;
    u_if.tx_we = 1'b0;
    u_if.overflow_clr = 1'b0;
    tick_n(3);
    chk("rst_tx", 32'(u_if.tx), 32'd1);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_full", 32'(u_if.fifo_full), 32'd0);
    chk("rst_count", 32'(u_if.fifo_count), 32'd0);
    chk("rst_overflow", 32'(u_if.overflow), 32'd0);
    rst = 1'b1;
    tick_n(2);

    // 1: single byte 0x55 and its exact waveform timing
    write_byte(8'h55, 1'b1);
    chk("t1_count_after_write", 32'(u_if.fifo_count), 32'd1);
    chk("t1_tx_still_idle", 32'(u_if.tx), 32'd1);
    tick();
    chk("t1_start_c1", 32'(u_if.tx), 32'd0);
    chk("t1_count_popped", 32'(u_if.fifo_count), 32'd0);
    chk("t1_busy", 32'(u_if.busy), 32'd1);
    tick_n(3);
    chk("t1_start_c4", 32'(u_if.tx), 32'd0);
    tick();
    chk("t1_bit0_c5", 32'(u_if.tx), 32'd1);
    tick_n(31);
    chk("t1_bit7_c36", 32'(u_if.tx), 32'd0);
    tick();
    chk("t1_stop_c37", 32'(u_if.tx), 32'd1);
    tick_n(3);
    chk("t1_stop_c40", 32'(u_if.tx), 32'd1);
    chk("t1_busy_c40", 32'(u_if.busy), 32'd1);
    tick();
    chk("t1_busy_c41", 32'(u_if.busy), 32'd0);
    tick_n(3);

    // 2: back-to-back frames with no idle gap
    write_byte(8'hA3, 1'b1);
    write_byte(8'h0F, 1'b1);
    tick_n(39);
    chk("t2_stop_c40", 32'(u_if.tx), 32'd1);
    tick();
    chk("t2_start2_c41", 32'(u_if.tx), 32'd0);
    wait_idle(200, "t2");

    // 3: overflow on the sixth consecutive write, then clear
    for (int i = 1; i <= 6; i++) begin
      write_byte(8'(i), i <= 5);
      u_if.tx_we = 1'b0;
      chk("t3_count", 32'(u_if.fifo_count), 32'(exp_cnt[i-1]));
      chk("t3_full", 32'(u_if.fifo_full), (i >= 5) ? 32'd1 : 32'd0);
      chk("t3_overflow", 32'(u_if.overflow), (i == 6) ? 32'd1 : 32'd0);
    end
    u_if.overflow_clr = 1'b1;
    tick();
    u_if.overflow_clr = 1'b0;
    chk("t3_overflow_clr", 32'(u_if.overflow), 32'd0);
    wait_idle(400, "t3");

    // 4: writes coinciding with the stop-bit pop, first while full then at count 3
    for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i), 1'b1);
    chk("t4_full", 32'(u_if.fifo_count), 32'd4);
    tick_n(36);
    write_byte(8'h15, 1'b0);
    chk("t4_drop_overflow", 32'(u_if.overflow), 32'd1);
    chk("t4_drop_count", 32'(u_if.fifo_count), 32'd3);
    tick_n(39);
    write_byte(8'h16, 1'b1);
    chk("t4_swap_count", 32'(u_if.fifo_count), 32'd3);
    chk("t4_overflow_sticky", 32'(u_if.overflow), 32'd1);
    u_if.overflow_clr = 1'b1;
    tick();
    u_if.overflow_clr = 1'b0;
    wait_idle(400, "t4");

    // 5: asynchronous reset during bit 3 of 0xFF with two bytes queued
    write_byte(8'hFF, 1'b1);
    write_byte(8'h33, 1'b1);
    write_byte(8'h44, 1'b1);
    tick_n(16);
    chk("t5_queued", 32'(u_if.fifo_count), 32'd2);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_tx", 32'(u_if.tx), 32'd1);
    chk("t5_rst_count", 32'(u_if.fifo_count), 32'd0);
    chk("t5_rst_busy", 32'(u_if.busy), 32'd0);
    tick_n(2);
    rst = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (u_if.tx !== 1'b1) low_seen = 1'b1;
    end
    chk("t5_quiet_after_reset", 32'(low_seen), 32'd0);
    chk("t5_busy_after_reset", 32'(u_if.busy), 32'd0);

    // 6: twelve spaced bytes across several pointer wraps
    for (int i = 0; i < 12; i++) begin
      write_byte(STREAM[i], 1'b1);
      tick_n(44);
    end
    wait_idle(200, "t6");

    chk("sb_all_received", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
